// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM states, requester indices and round-robin helpers
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, COMPLETE = 2'd2} state_t;
  localparam int REQ_CPU = 0;
  localparam int REQ_LOADER = 1;
  localparam int REQ_SCAN = 2;
  localparam int BURST_MAX_DEF = 4;
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return i == 2'(REQ_SCAN) ? 2'(REQ_CPU) : i + 2'd1;
  endfunction
  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    return oh[REQ_SCAN] ? 2'(REQ_SCAN) : oh[REQ_LOADER] ? 2'(REQ_LOADER) : 2'(REQ_CPU);
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester handshake and RAM strobes shared by the arbiter and its users
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [2:0] req, lock, we, gnt, done;
  logic [3*ADDR_W-1:0] addr_in;
  logic [3*DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0] rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_en, ram_we;
  modport slave (
    input req, lock, we, addr_in, wdata_in, ram_rdata,
    output gnt, done, rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output req, lock, we, addr_in, wdata_in, ram_rdata,
    input gnt, done, rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick3.sv
// rr_pick3: one-hot round-robin winner among three requesters, searching after last_grant
module rr_pick3 import mem_bus_arbiter_pkg::*; (
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [2:0] win
);
  logic [1:0] p0, p1, p2;
  // visit requesters in rotating priority order starting just after the previous winner
  always_comb begin
    p0 = rr_next(last_grant);
    p1 = rr_next(p0);
    p2 = rr_next(p1);
    win = req[p0] ? 3'b001 << p0 : req[p1] ? 3'b001 << p1 : req[p2] ? 3'b001 << p2 : 3'b000;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter with burst lock sharing one RAM port among three requesters
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input logic clk,
  input logic reset_cycle,
  mem_bus_arbiter_if.slave bus
);
  localparam int BW = $clog2(BURST_MAX + 1);
  state_t state, state_n;
  logic [1:0] win, last_grant, sel;
  logic [2:0] pick, win_oh;
  logic [BW-1:0] burst_cnt;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;
  logic we_r, load, fresh, cont;

  rr_pick3 u_pick (.req(bus.req), .last_grant(last_grant), .win(pick));

  // next state, winner selection and bus strobes; RAM sees only the registered winner's request
  always_comb begin
    win_oh = 3'b001 << win;
    fresh = state == IDLE && |bus.req;
    cont = state == COMPLETE && bus.req[win] && bus.lock[win] && burst_cnt < BW'(BURST_MAX - 1);
    load = fresh || cont;
    sel = fresh ? oh2idx(pick) : win;
    state_n = state == IDLE ? (fresh ? ACCESS : IDLE) : state == ACCESS ? COMPLETE : cont ? ACCESS : IDLE;
    bus.gnt = state == ACCESS ? win_oh : 3'b000;
    bus.done = state == COMPLETE ? win_oh : 3'b000;
    bus.ram_en = state == ACCESS;
    bus.ram_we = state == ACCESS && we_r;
    bus.ram_addr = addr_r;
    bus.ram_wdata = wdata_r;
    bus.rdata = state == COMPLETE && !we_r ? bus.ram_rdata : rdata_r;
  end

  // state register; any unused encoding falls back to IDLE through state_n
  always_ff @(posedge clk or posedge reset_cycle)
    if (reset_cycle) state <= IDLE;
    else state <= state_n;

  // capture the winner's request, round-robin history, burst length and last read data
  always_ff @(posedge clk or posedge reset_cycle)
    if (reset_cycle) begin
      win <= 2'(REQ_CPU);
      last_grant <= 2'(REQ_SCAN);
      burst_cnt <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      we_r <= 1'b0;
      rdata_r <= '0;
    end else begin
      if (load) begin
        win <= sel;
        we_r <= bus.we[sel];
        addr_r <= bus.addr_in[sel*ADDR_W +: ADDR_W];
        wdata_r <= bus.wdata_in[sel*DATA_W +: DATA_W];
      end
      if (fresh) last_grant <= sel;
      burst_cnt <= cont ? burst_cnt + 1'b1 : state == ACCESS ? burst_cnt : '0;
      if (state == COMPLETE && !we_r) rdata_r <= bus.ram_rdata;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed corner cases and randomized traffic against a transaction model
module tb_mem_bus_arbiter;
  localparam int BURST_MAX = 4;
  logic clk = 1'b0;
  logic reset_cycle = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mem [256];
  logic [7:0] smem [256];
  int cyc, acc_at, owner, run, lastg;
  logic m_we, e_en, e_we;
  logic [7:0] m_addr, m_wd, last_rd;
  logic [2:0] e_gnt, e_done;

  typedef struct {
    logic [2:0] req, we;
    logic [23:0] addr, wd;
    logic [2:0] gnt;
    logic e_we;
    logic [7:0] e_addr, e_wd, e_rd;
  } vec_t;
  vec_t tv [7];

  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset_cycle(reset_cycle), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_cycle = 1'b1;
    bus.req = '0;
    bus.lock = '0;
    bus.we = '0;
    bus.addr_in = '0;
    bus.wdata_in = '0;
    tick();
    tick();
    reset_cycle = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_en"}, bus.ram_en, 0);
    chk({tag, "_we"}, bus.ram_we, 0);
    chk({tag, "_addr"}, bus.ram_addr, 0);
    chk({tag, "_wdata"}, bus.ram_wdata, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
  endtask

  task automatic model_reset();
    cyc = 0;
    acc_at = -10;
    owner = 0;
    run = 0;
    lastg = 2;
    last_rd = 8'h00;
  endtask

  task automatic model_step();
    int w;
    cyc++;
    e_gnt = '0;
    e_done = '0;
    e_en = 1'b0;
    e_we = 1'b0;
    if (acc_at == cyc - 1) begin
      e_done = 3'b001 << owner;
      if (m_we) smem[m_addr] = m_wd;
      else last_rd = smem[m_addr];
    end else begin
      w = -1;
      if (acc_at == cyc - 2 && bus.req[owner] && bus.lock[owner] && run < BURST_MAX) begin
        w = owner;
        run++;
      end else if (acc_at < cyc - 2)
        for (int k = 1; k <= 3 && w < 0; k++)
          if (bus.req[(lastg + k) % 3]) begin
            w = (lastg + k) % 3;
            lastg = w;
            run = 1;
          end
      if (w >= 0) begin
        owner = w;
        acc_at = cyc;
        m_we = bus.we[w];
        m_addr = bus.addr_in[w*8 +: 8];
        m_wd = bus.wdata_in[w*8 +: 8];
        e_gnt = 3'b001 << w;
        e_en = 1'b1;
        e_we = m_we;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++)
      if (bus.done[i] || !bus.req[i]) begin
        bus.req[i] = 1'($urandom_range(0, 1));
        if (bus.req[i]) begin
          bus.lock[i] = 1'($urandom_range(0, 1));
          bus.we[i] = 1'($urandom_range(0, 1));
          bus.addr_in[i*8 +: 8] = 8'h80 | 8'($urandom_range(0, 3));
          bus.wdata_in[i*8 +: 8] = 8'($urandom);
        end
      end
  endtask

  initial begin
    logic [2:0] eg, ed;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h3C;
      smem[i] = 8'(i) ^ 8'h3C;
    end
    tv[0] = '{3'b111, 3'b001, 24'h30200F, 24'h3322A5, 3'b001, 1'b1, 8'h0F, 8'hA5, 8'h00};
    tv[1] = '{3'b010, 3'b000, 24'h300F11, 24'h3322A5, 3'b010, 1'b0, 8'h0F, 8'h22, 8'hA5};
    tv[2] = '{3'b101, 3'b100, 24'h400F0F, 24'h5A22A5, 3'b100, 1'b1, 8'h40, 8'h5A, 8'hA5};
    tv[3] = '{3'b011, 3'b000, 24'h400F40, 24'h5A22A5, 3'b001, 1'b0, 8'h40, 8'hA5, 8'h5A};
    tv[4] = '{3'b110, 3'b010, 24'h0F4000, 24'h5A77A5, 3'b010, 1'b1, 8'h40, 8'h77, 8'h5A};
    tv[5] = '{3'b100, 3'b000, 24'h400F0F, 24'h5A77A5, 3'b100, 1'b0, 8'h40, 8'h5A, 8'h77};
    tv[6] = '{3'b111, 3'b000, 24'h400F80, 24'h5A77A5, 3'b001, 1'b0, 8'h80, 8'hA5, 8'hBC};

    do_reset();
    chk_zero("reset");

    foreach (tv[i]) begin
      bus.req = tv[i].req;
      bus.we = tv[i].we;
      bus.addr_in = tv[i].addr;
      bus.wdata_in = tv[i].wd;
      tick();
      chk($sformatf("v%0d_gnt", i), bus.gnt, tv[i].gnt);
      chk($sformatf("v%0d_en", i), bus.ram_en, 1);
      chk($sformatf("v%0d_we", i), bus.ram_we, tv[i].e_we);
      chk($sformatf("v%0d_addr", i), bus.ram_addr, tv[i].e_addr);
      chk($sformatf("v%0d_wdata", i), bus.ram_wdata, tv[i].e_wd);
      chk($sformatf("v%0d_early_done", i), bus.done, 0);
      tick();
      chk($sformatf("v%0d_done", i), bus.done, tv[i].gnt);
      chk($sformatf("v%0d_rdata", i), bus.rdata, tv[i].e_rd);
      chk($sformatf("v%0d_gnt_off", i), bus.gnt, 0);
      bus.req = '0;
      tick();
    end

    do_reset();
    bus.req = 3'b111;
    for (int t = 1; t <= 12; t++) begin
      tick();
      eg = t % 3 == 1 ? 3'b001 << ((t - 1) / 3 % 3) : 3'b000;
      ed = t % 3 == 2 ? 3'b001 << ((t - 2) / 3 % 3) : 3'b000;
      chk($sformatf("rr_gnt_t%0d", t), bus.gnt, eg);
      chk($sformatf("rr_done_t%0d", t), bus.done, ed);
    end
    bus.req = '0;
    tick();
    tick();

    do_reset();
    bus.req = 3'b101;
    bus.lock = 3'b100;
    for (int t = 1; t <= 14; t++) begin
      tick();
      eg = (t == 1 || t == 13) ? 3'b001 : (t >= 4 && t <= 10 && t % 2 == 0) ? 3'b100 : 3'b000;
      chk($sformatf("burst_gnt_t%0d", t), bus.gnt, eg);
    end
    bus.req = '0;
    bus.lock = '0;
    tick();
    tick();

    do_reset();
    bus.req = 3'b001;
    bus.addr_in = 24'h000055;
    tick();
    chk("abort_gnt", bus.gnt, 3'b001);
    chk("abort_addr", bus.ram_addr, 8'h55);
    #2;
    reset_cycle = 1'b1;
    #1;
    chk_zero("abort");
    tick();
    chk("abort_nodone", bus.done, 0);
    bus.req = 3'b111;
    reset_cycle = 1'b0;
    tick();
    chk("abort_regnt", bus.gnt, 3'b001);
    tick();
    chk("abort_redone", bus.done, 3'b001);
    bus.req = '0;
    tick();
    tick();

    do_reset();
    bus.req = 3'b010;
    bus.addr_in = 24'h000F00;
    tick();
    chk("drop_gnt", bus.gnt, 3'b010);
    bus.req = '0;
    tick();
    chk("drop_done", bus.done, 3'b010);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("drop_quiet%0d", t), {bus.gnt, bus.done}, 0);
    end

    do_reset();
    model_reset();
    repeat (3000) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk($sformatf("rnd_gnt@%0d", cyc), bus.gnt, e_gnt);
      chk($sformatf("rnd_done@%0d", cyc), bus.done, e_done);
      chk($sformatf("rnd_en@%0d", cyc), {bus.ram_en, bus.ram_we}, {e_en, e_we});
      if (e_en) begin
        chk($sformatf("rnd_addr@%0d", cyc), bus.ram_addr, m_addr);
        chk($sformatf("rnd_wdata@%0d", cyc), bus.ram_wdata, m_wd);
      end
      chk($sformatf("rnd_rdata@%0d", cyc), bus.rdata, last_rd);
      drive();
    end
    bus.req = '0;
    tick();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Parameter BURST_MAX, default 4, maximum consecutive locked grants to one requester.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset_cycle  input  1  asynchronous, active-high reset.
REQ-006 req  input  3  per-requester access request (bit 0 CPU, bit 1 loader, bit 2 output scanner).
REQ-007 lock  input  3  per-requester burst-hold request, qualified by the matching req bit.
REQ-008 we  input  3  per-requester write enable.
REQ-009 addr_in  input  3*ADDR_W  packed per-requester addresses (requester i at [i*ADDR_W +: ADDR_W]).
REQ-010 wdata_in  input  3*DATA_W  packed per-requester write data.
REQ-011 gnt  output  3  one-hot grant, valid during ACCESS.
REQ-012 done  output  3  one-cycle completion pulse to the granted requester.
REQ-013 rdata  output  DATA_W  registered read data, valid while done is high.
REQ-014 ram_en, ram_we  output  1 each  RAM strobes.
REQ-015 ram_addr  output  ADDR_W  RAM address.
REQ-016 ram_wdata  output  DATA_W  RAM write data.
REQ-017 ram_rdata  input  DATA_W  RAM read data, valid one cycle after ram_en.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and COMPLETE, encoded in 2 bits.
REQ-019 IDLE: when any req bit is set, select a winner, register its addr/we/wdata and go to ACCESS; otherwise stay in IDLE.
REQ-020 Selection: round-robin, search starting at (last_grant+1) mod 3; last_grant updates on every grant.
REQ-021 ACCESS (exactly 1 cycle): gnt[winner]=1, ram_en=1, ram_we=we of winner, ram_addr/ram_wdata from the registered values; then go to COMPLETE.
REQ-022 COMPLETE (exactly 1 cycle): rdata <= ram_rdata on reads; rdata holds its previous value on writes; done[winner]=1.
REQ-023 Latency: req sampled in IDLE at edge T -> ACCESS during T+1 -> done during T+2; per-transaction throughput is 3 cycles.
REQ-024 Burst: in COMPLETE, if req[winner] and lock[winner] are both 1 and burst_cnt < BURST_MAX-1, go directly to ACCESS with the same winner, re-sample its inputs and increment burst_cnt (2-cycle throughput).
REQ-025 burst_cnt SHALL clear on every transition to IDLE and on every fresh grant; when the cap is reached the FSM SHALL return to IDLE and round-robin rearbitrates.
REQ-026 Requester protocol: req is held until done; a requester that keeps req high after done is treated as a new request.
REQ-027 Inputs of non-granted requesters SHALL never reach the RAM outputs; gnt and done SHALL always be one-hot or zero.
REQ-028 If req of the winner drops during ACCESS, the access still completes and done is still pulsed.
REQ-029 An out-of-range FSM encoding SHALL return to IDLE on the next edge.

Reset
REQ-030 On reset_cycle assertion (asynchronous): state=IDLE, gnt=0, done=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rdata=0, burst_cnt=0, last_grant=2 (so CPU wins first).
REQ-031 Reset mid-ACCESS SHALL abort the access with no done pulse; the requester re-requests.

Structure
REQ-032 State encodings, requester index constants (REQ_CPU=0, REQ_LOADER=1, REQ_SCAN=2) and BURST_MAX default SHALL live in the shared parameters include.
REQ-033 The round-robin winner selection SHALL be one combinational sub-module, rr_pick3 (inputs req, last_grant; output a one-hot winner).

Verification
REQ-034 After reset, req=3'b111 held -> grant order CPU, loader, scanner, CPU; done at cycles 2, 5, 8, 11 after the first sample.
REQ-035 CPU write addr=8'h0F data=8'hA5, then loader read addr=8'h0F -> ram_we pulses once; loader done with rdata=8'hA5.
REQ-036 Scanner with lock=1, req held, BURST_MAX=4, CPU also requesting -> 4 consecutive scanner grants 2 cycles apart, then CPU granted.
REQ-037 Reset asserted during ACCESS of a CPU read -> all outputs zero immediately, no done pulse; next grant goes to CPU.
REQ-038 Loader drops req during ACCESS -> done[1] still pulses once; FSM returns to IDLE with no further grant.
